// File: rtl/demux_pkg.sv
// Shared constants and helpers for the serial demux/deserializer slice.
package demux_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam bit LSB_FIRST = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  function automatic int sel_w_f(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/one_to_n_demux.sv
// One-hot write-enable decoder: the structural inverse of the 8:1 mux.
module one_to_n_demux
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = LSB_FIRST
) (
  input  logic [sel_w_f(WIDTH)-1:0] sel_i,
  input  logic                      en_i,
  output logic [WIDTH-1:0]          we_o
);

  localparam int SEL_W = sel_w_f(WIDTH);

  logic [SEL_W-1:0] idx;

  // WIDTH is a power of two, so WIDTH-1-sel is simply the bitwise inverse.
  assign idx = MSB_FIRST ? ~sel_i : sel_i;

  always_comb begin
    we_o      = '0;
    we_o[idx] = en_i;
  end

endmodule

// File: rtl/demux_deserializer.sv
// Serial-to-parallel deserializer: a select counter steers each accepted bit
// into a collect register; completed words leave through a valid/ready register.
module demux_deserializer
  import demux_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = LSB_FIRST
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic                      flush,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  output logic [sel_w_f(WIDTH)-1:0] sel
);

  localparam int               SEL_W    = sel_w_f(WIDTH);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // din_ready only drops for the final bit while a finished word is still unread.
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] collect_q, collect_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;

  logic             last_bit;
  logic             accept;
  logic [WIDTH-1:0] bit_we;
  logic [WIDTH-1:0] merged;

  assign last_bit  = (sel_q == SEL_LAST);
  assign din_ready = !(last_bit && dout_valid_q && !dout_ready);
  assign accept    = din_valid && din_ready && !flush;

  one_to_n_demux #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_decode (
    .sel_i (sel_q),
    .en_i  (accept),
    .we_o  (bit_we)
  );

  assign merged = (collect_q & ~bit_we) | (bit_we & {WIDTH{din}});

  always_comb begin
    sel_d        = sel_q;
    collect_d    = collect_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    if (flush) begin
      sel_d     = '0;
      collect_d = '0;
    end else if (accept) begin
      if (last_bit) begin
        // A load in the same cycle as a consume keeps valid high: no bubble.
        sel_d        = '0;
        collect_d    = '0;
        dout_d       = merged;
        dout_valid_d = 1'b1;
      end else begin
        sel_d     = sel_q + 1'b1;
        collect_d = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q        <= '0;
      collect_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      collect_q    <= collect_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sel        = sel_q;

endmodule
